// File: rtl/load_unit_bus.sv
// Multi-cycle load unit: one aligned word read over req/ack, then
// byte/half/word extraction with sign or zero extension.
module load_unit_bus #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        load_req_in,
  input  logic [1:0]  load_size_in,
  input  logic        load_unsigned_in,
  input  logic [31:0] addr_in,
  output logic        dmem_req_out,
  output logic [31:0] dmem_addr_out,
  input  logic        dmem_ack_in,
  input  logic [31:0] dmem_rdata_in,
  input  logic        dmem_err_in,
  output logic [31:0] lu_output_out,
  output logic        lu_valid_out,
  output logic        misaligned_out,
  output logic        bus_err_out,
  output logic        stall_out
);

  typedef enum logic [1:0] {
    IDLE,
    BUS,
    DONE
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [1:0]  off_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [7:0]  cnt_q;
  logic        accept;
  logic        misal;
  logic        done_ok;
  logic        done_err;
  logic        done_mis;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] ext;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  always_comb begin
    misal = 1'b0;
    if (load_size_in[1])
      misal = (addr_in[1:0] != 2'b00);
    else if (load_size_in[0])
      misal = addr_in[0];
    accept = (state != BUS) && load_req_in;
    stall_out = (state == BUS) || accept;
  end

  always_comb begin
    state_nx = state;
    done_ok  = 1'b0;
    done_err = 1'b0;
    done_mis = 1'b0;
    case (state)
      IDLE, DONE: begin
        state_nx = IDLE;
        if (load_req_in) begin
          if (misal) begin
            state_nx = DONE;
            done_mis = 1'b1;
          end else begin
            state_nx = BUS;
          end
        end
      end
      BUS: begin
        // error wins over a simultaneous ack
        if (dmem_err_in) begin
          state_nx = DONE;
          done_err = 1'b1;
        end else if (dmem_ack_in) begin
          state_nx = DONE;
          done_ok  = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          state_nx = DONE;
          done_err = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    byte_v = dmem_rdata_in[7:0];
    case (off_q)
      2'd1:    byte_v = dmem_rdata_in[15:8];
      2'd2:    byte_v = dmem_rdata_in[23:16];
      2'd3:    byte_v = dmem_rdata_in[31:24];
      default: byte_v = dmem_rdata_in[7:0];
    endcase
    half_v = off_q[1] ? dmem_rdata_in[31:16] : dmem_rdata_in[15:0];
    if (size_q[1])
      ext = dmem_rdata_in;
    else if (size_q[0])
      ext = {{16{~uns_q & half_v[15]}}, half_v};
    else
      ext = {{24{~uns_q & byte_v[7]}}, byte_v};
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state          <= IDLE;
      off_q          <= 2'b00;
      size_q         <= 2'b00;
      uns_q          <= 1'b0;
      cnt_q          <= 8'd0;
      dmem_req_out   <= 1'b0;
      dmem_addr_out  <= 32'd0;
      lu_output_out  <= 32'd0;
      lu_valid_out   <= 1'b0;
      misaligned_out <= 1'b0;
      bus_err_out    <= 1'b0;
    end else begin
      state          <= state_nx;
      lu_valid_out   <= done_ok;
      misaligned_out <= done_mis;
      bus_err_out    <= done_err;
      dmem_req_out   <= (state_nx == BUS);
      if (accept) begin
        off_q         <= addr_in[1:0];
        size_q        <= load_size_in;
        uns_q         <= load_unsigned_in;
        dmem_addr_out <= {addr_in[31:2], 2'b00};
      end
      if (state != BUS)
        cnt_q <= 8'd0;
      else if (!dmem_ack_in)
        cnt_q <= cnt_q + 8'd1;
      if (done_ok)
        lu_output_out <= ext;
    end
  end

endmodule

// File: doc/load_unit_bus.md
# load_unit_bus

Multi-cycle load unit between the execute-stage address adder and the write-back mux. Accepts a load request, reads one aligned word over a req/ack data-memory port, extracts and sign- or zero-extends the addressed byte, half or word, and presents the result as `lu_output_out`. That output feeds the write-back mux's load-unit input. Stalls the pipeline while the bus is outstanding and reports misaligned and bus-error completions.

## Interface
- `TIMEOUT_CYCLES`, default 255: maximum cycles in BUS without `dmem_ack_in` before a bus error is forced; legal range 2..255.
- `clk_in` input 1: single clock, rising edge.
- `rst_in` input 1: reset, asynchronous, active-high.
- `load_req_in` input 1: load request, sampled while the FSM is in IDLE or DONE.
- `load_size_in` input 2: 00 byte, 01 half, 10 word, 11 treated as word.
- `load_unsigned_in` input 1: 1 zero-extends, 0 sign-extends.
- `addr_in` input 32: byte address from the address adder.
- `dmem_req_out` output 1: bus request, high throughout BUS.
- `dmem_addr_out` output 32: word-aligned address `{addr[31:2],2'b00}`, stable while `dmem_req_out` is high.
- `dmem_ack_in` input 1: read data valid this cycle.
- `dmem_rdata_in` input 32: read word.
- `dmem_err_in` input 1: bus error, valid in BUS with or without ack.
- `lu_output_out` output 32: registered, extended load result.
- `lu_valid_out` output 1: one-cycle pulse when `lu_output_out` is updated.
- `misaligned_out` output 1: one-cycle pulse when a request was misaligned.
- `bus_err_out` output 1: one-cycle pulse on a bus error or timeout.
- `stall_out` output 1: combinational pipeline-freeze request.

## Operation
- FSM states: IDLE, BUS, DONE. Reset state is IDLE.
- Acceptance happens in IDLE or DONE when `load_req_in`=1. The unit registers `addr_in[1:0]`, the size and the unsigned flag, and loads the address register.
- Misalignment rule:
  - half: misaligned when `addr[0]`=1.
  - word (size 10 or 11): misaligned when `addr[1:0]`≠00.
  - byte: never misaligned.
- Transitions:
  - Aligned accept goes to BUS.
  - Misaligned accept goes to DONE with the misaligned flag set; no bus access is made.
  - In DONE with no request, the FSM goes to IDLE.
- In BUS:
  - `dmem_ack_in`=1 with `dmem_err_in`=0 captures the extracted data into `lu_output_out` and goes to DONE with the valid flag set.
  - `dmem_err_in`=1 takes priority over ack and goes to DONE with the error flag set.
  - The timeout counter is cleared on entry and increments each BUS cycle without ack. When it reaches `TIMEOUT_CYCLES-1` with no ack, the FSM goes to DONE with the error flag set.
- In DONE, exactly one of `lu_valid_out`, `misaligned_out`, `bus_err_out` is high, and only for that one cycle.
- On error or misalignment, `lu_output_out` keeps its previous value.
- Extraction:
  - byte lane = `addr[1:0]`.
  - half lane = `addr[1]`.
  - Result is bits [7:0] or [15:0] of the lane, extended to 32 bits by bit 7 or bit 15 unless unsigned.
  - Word loads pass through unchanged.
- Ignored events:
  - `dmem_ack_in` and `dmem_err_in` outside BUS, including a late ack after a timeout.
  - `load_req_in` while in BUS.
- `stall_out` = (state==BUS) OR (state∈{IDLE,DONE} AND `load_req_in`). It is low in a DONE cycle without a new request, so the pipeline advances with the result.

## Timing
- Reset values (asynchronous):
  - state IDLE.
  - `dmem_req_out`=0, `dmem_addr_out`=0, `lu_output_out`=0.
  - all pulses 0, timeout counter 0.
- `dmem_req_out` and `dmem_addr_out` are registered from state. The request rises in the cycle after acceptance.
- Minimum latency from accept edge to `lu_valid_out` is 2 cycles: accept at T0, BUS with ack at T1, DONE/valid at T2.
- Each extra wait cycle adds exactly 1 cycle.
- Back-to-back loads: a request accepted in DONE enters BUS the next cycle, so there are no idle bubbles.
- Timeout: with no ack, `bus_err_out` pulses `TIMEOUT_CYCLES`+1 cycles after acceptance.
- `rst_in` asserted mid-BUS drops `dmem_req_out` immediately with no completion pulse. Any pending ack is then ignored.

## Test plan
- LB at 0x1003, rdata 0x80FF_1234, ack in the first BUS cycle -> `lu_output_out`=0xFFFF_FF80, `lu_valid_out` pulse at T2, `dmem_addr_out`=0x1000, `stall_out` high for T0–T1.
- LHU at 0x2002, rdata 0xBEEF_0000, ack after 3 wait cycles -> `lu_output_out`=0x0000_BEEF, valid at T5.
- LW at 0x3001 -> no `dmem_req_out`, `misaligned_out` pulse at T1, `lu_output_out` unchanged.
- LW at 0x4000 with no ack, `TIMEOUT_CYCLES`=4 -> `bus_err_out` at T5; an ack at T6 is ignored and the FSM stays in IDLE.
- Back-to-back LB 0x5000 (rdata 0x0000_007F) then LH 0x5002 (rdata 0xF00D_0000, signed) -> valid 0x0000_007F then valid 0xFFFF_F00D, with the second request accepted in DONE.
- `rst_in` pulse during BUS with `dmem_err_in` pending -> all outputs 0 immediately, no pulse, FSM in IDLE.
